wb_dma_mem_responder: RTL and testbench
=======================================

// Module: wb_dma_mem_responder
// PURPOSE
// Wishbone responder that serves the user-area buffer memory to two masters: the CPU (wbs_*) and the DMA engine (dma_*).
// It returns a one-cycle ack after a programmable wait, models BRAM access latency, and arbitrates the two ports round-robin.
// It is the slave end of the DMA's memory reads/writes and supplies the DMA's dma_ack and read data.
// PARAMETERS
// BASE_ADDR  32'h3800_0000  byte base of the memory window
// ADDR_BITS  10             log2 of depth in 32-bit words (1024 words = 4 KB window)
// DELAY      10             wait cycles between acceptance and ack (0..31)
// PORTS
// wb_clk_i    in   1   clock
// wb_rst_i    in   1   reset
// wbs_cyc_i   in   1   CPU cycle
// wbs_stb_i   in   1   CPU strobe
// wbs_we_i    in   1   CPU write enable
// wbs_sel_i   in   4   CPU byte lanes
// wbs_adr_i   in   32  CPU byte address
// wbs_dat_i   in   32  CPU write data
// wbs_ack_o   out  1   CPU ack (1-cycle pulse)
// wbs_dat_o   out  32  CPU read data, valid with ack
// dma_cyc_i   in   1   DMA cycle
// dma_stb_i   in   1   DMA strobe
// dma_we_i    in   1   DMA write enable
// dma_sel_i   in   4   DMA byte lanes
// dma_adr_i   in   32  DMA byte address
// dma_dat_i   in   32  DMA write data
// dma_ack_o   out  1   DMA ack (1-cycle pulse)
// dma_dat_o   out  32  DMA read data, valid with ack
// busy_o      out  1   high while an access is in WAIT
// BEHAVIOUR
// - Reset: wb_rst_i, asynchronous, active-high; clock wb_clk_i.
// - Reset values: all acks 0, all dat_o 0, busy_o 0, FSM IDLE, last_grant=DMA (CPU wins first tie). Memory contents are not reset.
// - Request = cyc & stb. In-window when adr[31:ADDR_BITS+2]==BASE_ADDR[31:ADDR_BITS+2]; word index = adr[ADDR_BITS+1:2]; adr[1:0] ignored.
// - FSM IDLE -> WAIT:
//   - On any request: latch port, we, sel, index, data; cnt<=DELAY; busy_o<=1.
//   - Tie (both request): grant port != last_grant, then update last_grant. Single request: grant it, update last_grant.
// - FSM WAIT:
//   - If granted port drops cyc: abort -> IDLE, no ack, no write, busy_o<=0.
//   - Else cnt==0: -> ACK. Raise that port's ack for exactly one cycle (registered). Read data loaded into that port's dat_o on the same edge.
//   - Else cnt<=cnt-1.
// - Write commits at the edge raising ack, per sel lane. sel=0000 is acked with no change.
// - Out-of-window access: acked normally, read returns 0, write ignored.
// - Latency: request first sampled at edge E -> ack high in the cycle after edge E+DELAY+1 (DELAY=0: ack one cycle after request seen).
// - FSM ACK -> IDLE next cycle, ack cleared.
//   - A request still held in IDLE starts a new access, so a held stb re-accesses. Masters drop stb after ack.
//   - Back-to-back same-port throughput: 1 access per DELAY+3 cycles.
// - The non-granted port waits with ack=0 and is served next (no starvation). dat_o holds its value until the next ack to that port.
// - Reset mid-access: FSM->IDLE, pending write discarded, ack low.
// TESTING
// 1. Reset: assert wb_rst_i async mid-cycle -> all acks, dat_o, busy_o = 0 immediately.
// 2. CPU write 0xDEADBEEF @0x38000100 sel=1111 -> ack DELAY+2 cycles after request. DMA read same address -> dma_dat_o=0xDEADBEEF with dma_ack.
// 3. Preload 0x11223344, CPU write 0x0000AB00 sel=0010 -> readback 0x1122AB44.
// 4. After reset, both ports request simultaneously, held -> CPU acked first, DMA acked DELAY+3 cycles later. Repeat tie -> DMA first.
// 5. DMA write 0x5555AAAA, drop cyc at wait cycle 3 -> no ack, memory unchanged. Next CPU access serviced normally.
// 6. CPU read 0x30000000 -> ack with wbs_dat_o=0. Write there -> no in-window word changes. Reset during WAIT -> no ack, no write.

Source files
------------

// File: rtl/wb_dma_mem_responder.sv
// Wishbone buffer-memory responder shared by the CPU and DMA ports.
// Round-robin arbitration, programmable ack delay, byte-lane writes, abort on cyc drop.
module wb_dma_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter int          ADDR_BITS = 10,
  parameter int          DELAY     = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        dma_cyc_i,
  input  logic        dma_stb_i,
  input  logic        dma_we_i,
  input  logic [3:0]  dma_sel_i,
  input  logic [31:0] dma_adr_i,
  input  logic [31:0] dma_dat_i,
  output logic        dma_ack_o,
  output logic [31:0] dma_dat_o,
  output logic        busy_o
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;
  typedef enum logic {PORT_CPU = 1'b0, PORT_DMA = 1'b1} port_t;

  state_t r_state;
  state_t w_stateNext;
  port_t  r_grant;
  port_t  r_lastGrant;
  port_t  w_grantSel;
  port_t  w_lastNext;

  logic [4:0]           r_cnt;
  logic [4:0]           w_cntNext;
  logic                 r_we;
  logic [3:0]           r_sel;
  logic [ADDR_BITS-1:0] r_idx;
  logic                 r_inWin;
  logic [31:0]          r_wdat;
  logic                 r_ackCpu;
  logic                 r_ackDma;
  logic [31:0]          r_datCpu;
  logic [31:0]          r_datDma;
  logic                 r_busy;
  logic [31:0]          r_mem [0:DEPTH-1];

  logic        w_cpuReq;
  logic        w_dmaReq;
  logic        w_start;
  logic        w_commit;
  logic        w_ackCpuNext;
  logic        w_ackDmaNext;
  logic        w_grantCyc;
  logic        w_reqWe;
  logic [3:0]  w_reqSel;
  logic [31:0] w_reqAdr;
  logic [31:0] w_reqDat;
  logic [31:0] w_rdData;
  logic        w_unused;

  assign w_cpuReq = wbs_cyc_i & wbs_stb_i;
  assign w_dmaReq = dma_cyc_i & dma_stb_i;

  // Request fields of whichever port wins arbitration this cycle
  assign w_reqWe  = (w_grantSel == PORT_CPU) ? wbs_we_i  : dma_we_i;
  assign w_reqSel = (w_grantSel == PORT_CPU) ? wbs_sel_i : dma_sel_i;
  assign w_reqAdr = (w_grantSel == PORT_CPU) ? wbs_adr_i : dma_adr_i;
  assign w_reqDat = (w_grantSel == PORT_CPU) ? wbs_dat_i : dma_dat_i;
  assign w_unused = &{1'b0, w_reqAdr[1:0]};

  assign w_grantCyc = (r_grant == PORT_CPU) ? wbs_cyc_i : dma_cyc_i;
  assign w_rdData   = r_inWin ? r_mem[r_idx] : 32'h0;

  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_lastNext   = r_lastGrant;
    w_start      = 1'b0;
    w_commit     = 1'b0;
    w_ackCpuNext = 1'b0;
    w_ackDmaNext = 1'b0;
    w_grantSel   = PORT_CPU;
    if (w_cpuReq && w_dmaReq) begin
      w_grantSel = (r_lastGrant == PORT_CPU) ? PORT_DMA : PORT_CPU;
    end else if (w_dmaReq) begin
      w_grantSel = PORT_DMA;
    end
    case (r_state)
      ST_IDLE: begin
        if (w_cpuReq || w_dmaReq) begin
          w_start     = 1'b1;
          w_stateNext = ST_WAIT;
          w_cntNext   = 5'(DELAY);
          w_lastNext  = w_grantSel;
        end
      end
      ST_WAIT: begin
        // Dropping cyc abandons the access before anything is written
        if (!w_grantCyc) begin
          w_stateNext = ST_IDLE;
        end else if (r_cnt == 5'd0) begin
          w_stateNext  = ST_ACK;
          w_ackCpuNext = (r_grant == PORT_CPU);
          w_ackDmaNext = (r_grant == PORT_DMA);
          w_commit     = r_we && r_inWin;
        end else begin
          w_cntNext = r_cnt - 5'd1;
        end
      end
      ST_ACK: begin
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 5'd0;
      r_grant     <= PORT_CPU;
      r_lastGrant <= PORT_DMA;
      r_we        <= 1'b0;
      r_sel       <= 4'h0;
      r_idx       <= '0;
      r_inWin     <= 1'b0;
      r_wdat      <= 32'h0;
      r_ackCpu    <= 1'b0;
      r_ackDma    <= 1'b0;
      r_datCpu    <= 32'h0;
      r_datDma    <= 32'h0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_cnt       <= w_cntNext;
      r_lastGrant <= w_lastNext;
      r_ackCpu    <= w_ackCpuNext;
      r_ackDma    <= w_ackDmaNext;
      r_busy      <= (w_stateNext == ST_WAIT);
      if (w_start) begin
        r_grant <= w_grantSel;
        r_we    <= w_reqWe;
        r_sel   <= w_reqSel;
        r_idx   <= w_reqAdr[ADDR_BITS+1:2];
        r_inWin <= (w_reqAdr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
        r_wdat  <= w_reqDat;
      end
      // Read data is captured on the ack edge; writes leave dat_o untouched
      if (w_ackCpuNext && !r_we) begin
        r_datCpu <= w_rdData;
      end
      if (w_ackDmaNext && !r_we) begin
        r_datDma <= w_rdData;
      end
    end
  end

  // Buffer storage: contents survive reset, lanes written on the ack edge
  always_ff @(posedge wb_clk_i) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_sel[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wdat[8*b +: 8];
        end
      end
    end
  end

  assign wbs_ack_o = r_ackCpu;
  assign dma_ack_o = r_ackDma;
  assign wbs_dat_o = r_datCpu;
  assign dma_dat_o = r_datDma;
  assign busy_o    = r_busy;

endmodule

// File: tb/tb_wb_dma_mem_responder.sv
// Directed bench for wb_dma_mem_responder: scoreboard of expected acks,
// checked for latency, read data and single-cycle pulse width.
module tb_wb_dma_mem_responder;

  localparam int D  = 10;
  localparam int TO = 4*D + 40;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        dma_cyc_i, dma_stb_i, dma_we_i;
  logic [3:0]  dma_sel_i;
  logic [31:0] dma_adr_i, dma_dat_i;
  logic        dma_ack_o;
  logic [31:0] dma_dat_o;
  logic        busy_o;

  typedef struct {
    bit          port;
    bit          isRead;
    logic [31:0] data;
    int          latency;
    int          startCyc;
    string       tag;
  } exp_t;

  exp_t sbQ[$];
  int checks = 0;
  int errors = 0;
  int cycleCount = 0;

  wb_dma_mem_responder #(
    .BASE_ADDR(32'h3800_0000),
    .ADDR_BITS(10),
    .DELAY(D)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .dma_cyc_i(dma_cyc_i), .dma_stb_i(dma_stb_i), .dma_we_i(dma_we_i),
    .dma_sel_i(dma_sel_i), .dma_adr_i(dma_adr_i), .dma_dat_i(dma_dat_i),
    .dma_ack_o(dma_ack_o), .dma_dat_o(dma_dat_o),
    .busy_o(busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cycleCount++;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit port, input bit we, input logic [3:0] sel,
                               input logic [31:0] adr, input logic [31:0] dat);
    if (!port) begin
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
    end else begin
      dma_cyc_i = 1'b1; dma_stb_i = 1'b1; dma_we_i = we;
      dma_sel_i = sel;  dma_adr_i = adr;  dma_dat_i = dat;
    end
  endtask

  task automatic releasePort(input bit port);
    if (!port) begin
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    end else begin
      dma_cyc_i = 1'b0; dma_stb_i = 1'b0;
    end
  endtask

  task automatic expectAck(input bit port, input bit isRead, input logic [31:0] data,
                           input int latency, input string tag);
    exp_t e;
    e.port = port; e.isRead = isRead; e.data = data;
    e.latency = latency; e.startCyc = cycleCount; e.tag = tag;
    sbQ.push_back(e);
  endtask

  // Pops the oldest expectation and waits (bounded) for that port's ack
  task automatic checkOutput();
    exp_t e;
    int   waited;
    bit   seen;
    if (sbQ.size() == 0) begin
      checks++; errors++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=entry");
      return;
    end
    e = sbQ.pop_front();
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < TO) begin
      @(negedge wb_clk_i);
      waited++;
      seen = e.port ? dma_ack_o : wbs_ack_o;
    end
    if (!seen) begin
      checks++; errors++;
      $error("[TB] FAIL %s_timeout observed=no_ack expected=ack", e.tag);
      releasePort(e.port);
      return;
    end
    checkVal({e.tag, "_lat"}, 32'(cycleCount - e.startCyc), 32'(e.latency));
    if (e.isRead) checkVal({e.tag, "_data"}, e.port ? dma_dat_o : wbs_dat_o, e.data);
    releasePort(e.port);
    @(negedge wb_clk_i);
    checkVal({e.tag, "_pulse"}, {31'h0, e.port ? dma_ack_o : wbs_ack_o}, 32'h0);
  endtask

  task automatic access(input bit port, input bit we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input logic [31:0] expData, input string tag);
    @(negedge wb_clk_i);
    applyStimulus(port, we, sel, adr, dat);
    expectAck(port, !we, expData, D + 2, tag);
    checkOutput();
  endtask

  initial begin
    bit sawAck;
    wb_rst_i = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    dma_cyc_i = 0; dma_stb_i = 0; dma_we_i = 0; dma_sel_i = 0; dma_adr_i = 0; dma_dat_i = 0;
    #12;
    checkVal("rst_wbsAck", {31'h0, wbs_ack_o}, 32'h0);
    checkVal("rst_dmaAck", {31'h0, dma_ack_o}, 32'h0);
    checkVal("rst_wbsDat", wbs_dat_o, 32'h0);
    checkVal("rst_dmaDat", dma_dat_o, 32'h0);
    checkVal("rst_busy",   {31'h0, busy_o}, 32'h0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // CPU full-word write, then DMA reads it back
    @(negedge wb_clk_i);
    applyStimulus(1'b0, 1'b1, 4'hF, 32'h3800_0100, 32'hDEAD_BEEF);
    expectAck(1'b0, 1'b0, 32'h0, D + 2, "cpuWr");
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    checkVal("busyInWait", {31'h0, busy_o}, 32'h1);
    checkOutput();
    access(1'b1, 1'b0, 4'hF, 32'h3800_0100, 32'h0, 32'hDEAD_BEEF, "dmaRd");

    // Byte-lane merge and empty-lane write
    access(1'b0, 1'b1, 4'hF, 32'h3800_0104, 32'h1122_3344, 32'h0, "preload");
    access(1'b0, 1'b1, 4'h2, 32'h3800_0104, 32'h0000_AB00, 32'h0, "laneWr");
    access(1'b0, 1'b1, 4'h0, 32'h3800_0104, 32'hFFFF_FFFF, 32'h0, "sel0Wr");
    access(1'b0, 1'b0, 4'hF, 32'h3800_0104, 32'h0, 32'h1122_AB44, "laneRd");

    // Tie after reset: CPU first, DMA served DELAY+3 later
    @(negedge wb_clk_i); wb_rst_i = 1'b1;
    @(negedge wb_clk_i); wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    applyStimulus(1'b0, 1'b0, 4'hF, 32'h3800_0100, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h3800_0104, 32'h0);
    expectAck(1'b0, 1'b1, 32'hDEAD_BEEF, D + 2, "tie1Cpu");
    expectAck(1'b1, 1'b1, 32'h1122_AB44, 2*D + 5, "tie1Dma");
    checkOutput();
    checkOutput();

    // Last grant to CPU, so the next tie goes to DMA
    access(1'b0, 1'b0, 4'hF, 32'h3800_0104, 32'h0, 32'h1122_AB44, "soloCpu");
    @(negedge wb_clk_i);
    applyStimulus(1'b0, 1'b0, 4'hF, 32'h3800_0104, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h3800_0100, 32'h0);
    expectAck(1'b1, 1'b1, 32'hDEAD_BEEF, D + 2, "tie2Dma");
    expectAck(1'b0, 1'b1, 32'h1122_AB44, 2*D + 5, "tie2Cpu");
    checkOutput();
    checkOutput();

    // DMA write aborted by dropping cyc mid-wait
    @(negedge wb_clk_i);
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h3800_0100, 32'h5555_AAAA);
    repeat (4) @(negedge wb_clk_i);
    releasePort(1'b1);
    sawAck = 1'b0;
    for (int i = 0; i < 2*D; i++) begin
      @(negedge wb_clk_i);
      sawAck |= dma_ack_o;
    end
    checkVal("abortNoAck", {31'h0, sawAck}, 32'h0);
    checkVal("abortBusy", {31'h0, busy_o}, 32'h0);
    access(1'b0, 1'b0, 4'hF, 32'h3800_0100, 32'h0, 32'hDEAD_BEEF, "abortRd");

    // Out-of-window read and write
    access(1'b0, 1'b0, 4'hF, 32'h3000_0000, 32'h0, 32'h0, "oowRd");
    access(1'b0, 1'b1, 4'hF, 32'h3000_0100, 32'h1234_5678, 32'h0, "oowWr");
    access(1'b0, 1'b0, 4'hF, 32'h3800_0100, 32'h0, 32'hDEAD_BEEF, "oowChk");

    // Asynchronous reset in the middle of a pending write
    @(negedge wb_clk_i);
    applyStimulus(1'b0, 1'b1, 4'hF, 32'h3800_0104, 32'hFFFF_FFFF);
    repeat (3) @(negedge wb_clk_i);
    checkVal("preRstBusy", {31'h0, busy_o}, 32'h1);
    @(posedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    checkVal("midRst_wbsAck", {31'h0, wbs_ack_o}, 32'h0);
    checkVal("midRst_wbsDat", wbs_dat_o, 32'h0);
    checkVal("midRst_dmaDat", dma_dat_o, 32'h0);
    checkVal("midRst_busy",   {31'h0, busy_o}, 32'h0);
    releasePort(1'b0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    access(1'b0, 1'b0, 4'hF, 32'h3800_0104, 32'h0, 32'h1122_AB44, "rstNoWr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
